// File: rtl/dpram_pkg.sv
`default_nettype none
// ============================================================================
// Module : dpram_pkg -- shared DPRAM widths and burst FSM encoding
// Rev    : 1.0
// ============================================================================
package dpram_pkg;

    localparam int DPRAM_ADDR_W = 4;
    localparam int DPRAM_DATA_W = 4;

    // Cycles spent in DRAIN before the final read beat lands on rd_valid
    localparam int DRAIN_CYCLES = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dpram_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module : dpram_rd_pipe -- aligns DPRAM read data to its issued address
// Rev    : 1.0
// ============================================================================
module dpram_rd_pipe
    import dpram_pkg::*;
#(
    parameter int DATA_W = DPRAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_i,
    input  logic [DATA_W-1:0] ram_data_i,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [1:0]        vld_q;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;

    // Stage 0 tracks the address edge, stage 1 the RAM output cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q      <= 2'b00;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            vld_q      <= {vld_q[0], issue_i};
            rd_valid_q <= vld_q[1];
            if (vld_q[1]) begin
                rd_data_q <= ram_data_i;
            end
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/dpram_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module : dpram_burst_ctrl -- read/write burst engine on DPRAM port 1
// Rev    : 1.0
// ============================================================================
module dpram_burst_ctrl
    import dpram_pkg::*;
#(
    parameter int ADDR_W = DPRAM_ADDR_W,
    parameter int DATA_W = DPRAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rd,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr1,
    output logic [DATA_W-1:0] data_in1,
    output logic              we1,
    input  logic [DATA_W-1:0] data_out1
);

    localparam logic [ADDR_W:0]   c_CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   c_DRAIN_END = (ADDR_W+1)'(DRAIN_CYCLES - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr1_q, addr1_d;
    logic [DATA_W-1:0] data_in1_q, data_in1_d;
    logic              we1_q, we1_d;
    logic              done_q, done_d;

    logic              w_cmd_hs;
    logic              w_wr_hs;
    logic              w_wr_last;
    logic              w_issue;
    logic [ADDR_W:0]   w_len_ext;
    logic [ADDR_W-1:0] w_addr_inc;

    // Gated by rst so the port reads low while reset is held
    assign cmd_ready  = (state_q == ST_IDLE) && rst;
    assign w_len_ext  = {1'b0, len_q};
    assign w_wr_last  = (cnt_q == (w_len_ext + c_CNT_ONE));
    assign wr_ready   = (state_q == ST_WRITE) && !w_wr_last;
    assign w_cmd_hs   = cmd_valid && cmd_ready;
    assign w_wr_hs    = wr_valid && wr_ready;
    assign w_addr_inc = addr_q + c_ADDR_ONE;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        addr1_d    = addr1_q;
        data_in1_d = data_in1_q;
        we1_d      = 1'b0;
        done_d     = 1'b0;
        w_issue    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_cmd_hs) begin
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    cnt_d   = '0;
                    state_d = cmd_rd ? ST_READ : ST_WRITE;
                end
            end

            ST_WRITE: begin
                if (w_wr_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (w_wr_hs) begin
                    we1_d      = 1'b1;
                    addr1_d    = addr_q;
                    data_in1_d = wr_data;
                    addr_d     = w_addr_inc;
                    cnt_d      = cnt_q + c_CNT_ONE;
                end
            end

            ST_READ: begin
                w_issue = 1'b1;
                addr1_d = addr_q;
                addr_d  = w_addr_inc;
                cnt_d   = cnt_q + c_CNT_ONE;
                if (cnt_q == w_len_ext) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end
            end

            ST_DRAIN: begin
                // Leave as the last issued beat reaches rd_valid
                if (cnt_q == c_DRAIN_END) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            addr1_q    <= '0;
            data_in1_q <= '0;
            we1_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            addr1_q    <= addr1_d;
            data_in1_q <= data_in1_d;
            we1_q      <= we1_d;
            done_q     <= done_d;
        end
    end

    dpram_rd_pipe #(
        .DATA_W (DATA_W)
    ) u_rd_pipe (
        .clk        (clk),
        .rst        (rst),
        .issue_i    (w_issue),
        .ram_data_i (data_out1),
        .rd_valid_o (rd_valid),
        .rd_data_o  (rd_data)
    );

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign addr1    = addr1_q;
    assign data_in1 = data_in1_q;
    assign we1      = we1_q;

endmodule
`default_nettype wire

// File: tb/tb_dpram_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_dpram_burst_ctrl -- scoreboard bench for dpram_burst_ctrl
// Rev    : 1.0
// ============================================================================
module tb_dpram_burst_ctrl;

    localparam int AW = 4;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_rd;
    logic [AW-1:0] cmd_addr, cmd_len;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          busy, done;
    logic [AW-1:0] addr1;
    logic [DW-1:0] data_in1, data_out1;
    logic          we1;

    always #5 clk = ~clk;

    dpram_burst_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rd    (cmd_rd),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .addr1     (addr1),
        .data_in1  (data_in1),
        .we1       (we1),
        .data_out1 (data_out1)
    );

    // Synchronous DPRAM port 1: data_out1 valid the cycle after addr1 is sampled
    logic [DW-1:0] ram     [16];
    logic [DW-1:0] ref_mem [16];
    always @(posedge clk) begin
        if (we1) ram[addr1] <= data_in1;
        data_out1 <= ram[addr1];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; int c; } wr_exp_t;
    typedef struct { logic [DW-1:0] d; int c; } rd_exp_t;
    wr_exp_t exp_wr[$];
    rd_exp_t exp_rd[$];
    int      exp_done[$];

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : mon
        wr_exp_t we_e;
        rd_exp_t rd_e;
        int      dn;
        if (we1 === 1'b1) begin
            if (exp_wr.size() == 0) check("we1_unexpected", we1, 1'b0);
            else begin
                we_e = exp_wr.pop_front();
                check("wr_addr", addr1, we_e.a);
                check("wr_data", data_in1, we_e.d);
                check("wr_cycle", cyc, we_e.c);
            end
        end
        if (rd_valid === 1'b1) begin
            if (exp_rd.size() == 0) check("rd_valid_unexpected", rd_valid, 1'b0);
            else begin
                rd_e = exp_rd.pop_front();
                check("rd_data", rd_data, rd_e.d);
                check("rd_cycle", cyc, rd_e.c);
            end
        end
        if (done === 1'b1) begin
            if (exp_done.size() == 0) check("done_unexpected", done, 1'b0);
            else begin
                dn = exp_done.pop_front();
                check("done_cycle", cyc, dn);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge with cmd_valid still high
    task automatic send_cmd(input logic rd, input logic [AW-1:0] a, input logic [AW-1:0] l,
                            output int acc);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_rd    = rd;
        cmd_addr  = a;
        cmd_len   = l;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("cmd_timeout", cmd_ready, 1'b1);
        acc = cyc + 1;
        @(negedge clk);
    endtask

    task automatic write_beats(input logic [AW-1:0] a, input int nb, input logic [63:0] dv,
                               input bit gaps, output int last);
        int            k  = 0;
        int            n  = 0;
        bit            on = 1'b1;
        logic [AW-1:0] ad;
        last = 0;
        while (k < nb && n < 200) begin
            wr_valid = gaps ? on : 1'b1;
            wr_data  = dv[k*DW +: DW];
            if (wr_valid && wr_ready) begin
                ad = a + AW'(k);
                exp_wr.push_back('{ad, wr_data, cyc + 1});
                ref_mem[ad] = wr_data;
                last = cyc + 1;
                k++;
                if (k == nb) exp_done.push_back(cyc + 2);
            end
            on = !on;
            n++;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        if (k < nb) check("wr_timeout", k, nb);
    endtask

    task automatic push_reads(input logic [AW-1:0] a, input logic [AW-1:0] l, input int acc);
        for (int k = 0; k <= int'(l); k++) exp_rd.push_back('{ref_mem[a + AW'(k)], acc + 3 + k});
        exp_done.push_back(acc + 3 + int'(l));
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_wr.size() + exp_rd.size() + exp_done.size()) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("queue_drain", exp_wr.size() + exp_rd.size() + exp_done.size(), 0);
        repeat (2) @(negedge clk);
        check("busy_after", busy, 1'b0);
    endtask

    task automatic write_burst(input logic [AW-1:0] a, input logic [AW-1:0] l,
                               input logic [63:0] dv, input bit gaps);
        int acc, last;
        send_cmd(1'b0, a, l, acc);
        cmd_valid = 1'b0;
        write_beats(a, int'(l) + 1, dv, gaps, last);
        drain();
    endtask

    task automatic read_burst(input logic [AW-1:0] a, input logic [AW-1:0] l);
        int acc;
        send_cmd(1'b1, a, l, acc);
        cmd_valid = 1'b0;
        push_reads(a, l, acc);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, last;
        for (int i = 0; i < 16; i++) begin
            ram[i]     = '0;
            ref_mem[i] = '0;
        end
        rst = 1'b0; cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_we1", we1, 1'b0);
        check("rst_addr1", addr1, 4'h0);
        check("rst_data_in1", data_in1, 4'h0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_rd_data", rd_data, 4'h0);
        check("rst_done", done, 1'b0);
        rst = 1'b1;
        #1 check("cmd_ready_after_rst", cmd_ready, 1'b1);
        @(negedge clk);

        write_burst(4'd2, 4'd3, 64'hDCBA, 1'b0);
        read_burst(4'd2, 4'd3);

        write_burst(4'd14, 4'd3, 64'h4321, 1'b0);
        read_burst(4'd14, 4'd3);

        write_burst(4'd6, 4'd3, 64'h8765, 1'b1);
        read_burst(4'd6, 4'd3);

        // Single-beat write then a two-beat read across the wrap
        write_burst(4'd0, 4'd0, 64'hF, 1'b0);
        read_burst(4'd15, 4'd1);

        // cmd_valid held through a write: the queued read waits for done
        send_cmd(1'b0, 4'd8, 4'd1, acc);
        cmd_rd = 1'b1;
        write_beats(4'd8, 2, 64'hE9, 1'b0, last);
        send_cmd(1'b1, 4'd8, 4'd1, acc2);
        cmd_valid = 1'b0;
        check("hold_accept_edge", acc2, last + 2);
        push_reads(4'd8, 4'd1, acc2);
        drain();

        // Reset after two read addresses have been issued
        send_cmd(1'b1, 4'd2, 4'd5, acc);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("rd_addr_first", addr1, 4'd2);
        @(negedge clk);
        check("rd_addr_second", addr1, 4'd3);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_we1", we1, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_rd_valid", rd_valid, 1'b0);
        check("midrst_rd_data", rd_data, 4'h0);
        check("midrst_addr1", addr1, 4'h0);
        check("midrst_cmd_ready", cmd_ready, 1'b0);
        rst = 1'b1;
        #1 check("midrst_cmd_ready_release", cmd_ready, 1'b1);
        repeat (6) @(negedge clk);
        check("midrst_idle", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dpram_burst_ctrl.md
DPRAM_BURST_CTRL -- requirements
Module: dpram_burst_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, DPRAM address width.
REQ-002 SHALL have parameter DATA_W, default 4, DPRAM data width.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  synchronous reset, active-low.
REQ-005 SHALL have port cmd_valid  input  1  burst command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when cmd_valid&&cmd_ready.
REQ-007 SHALL have port cmd_rd  input  1  1=read burst, 0=write burst.
REQ-008 SHALL have port cmd_addr  input  ADDR_W  burst start address.
REQ-009 SHALL have port cmd_len  input  ADDR_W  beats minus one (1..16 beats).
REQ-010 SHALL have port wr_valid  input  1  write beat offered.
REQ-011 SHALL have port wr_ready  output  1  write beat accepted when wr_valid&&wr_ready.
REQ-012 SHALL have port wr_data  input  DATA_W  write beat data.
REQ-013 SHALL have port rd_valid  output  1  read beat valid; no backpressure.
REQ-014 SHALL have port rd_data  output  DATA_W  read beat data.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse at burst completion.
REQ-017 SHALL have port addr1  output  ADDR_W  DPRAM port-1 address.
REQ-018 SHALL have port data_in1  output  DATA_W  DPRAM port-1 write data.
REQ-019 SHALL have port we1  output  1  DPRAM port-1 write enable.
REQ-020 SHALL have port data_out1  input  DATA_W  DPRAM port-1 read data, valid one cycle after addr1 sampled.

Function
REQ-021 SHALL implement FSM states IDLE, WRITE, READ, DRAIN.
REQ-022 SHALL assert cmd_ready only in IDLE; handshake latches addr, len, rd; next state WRITE (cmd_rd=0) or READ (cmd_rd=1).
REQ-023 SHALL assert wr_ready only in WRITE.
REQ-024 SHALL, per write handshake at edge N, drive addr1/data_in1 and we1=1 registered from edge N for exactly one cycle; we1=0 in cycles without a handshake.
REQ-025 SHALL issue one new addr1 per cycle in READ, with we1=0, for len+1 consecutive cycles, then enter DRAIN.
REQ-026 SHALL register data_out1 into rd_data with rd_valid=1 exactly 2 cycles after the corresponding addr1 is first driven.
REQ-027 SHALL increment address by 1 per beat modulo 2^ADDR_W (15 wraps to 0).
REQ-028 SHALL, in WRITE, return to IDLE the cycle after the last beat (beat count = len+1) is driven, pulsing done in that cycle.
REQ-029 SHALL, in DRAIN, pulse done together with the final rd_valid, then return to IDLE.
REQ-030 SHALL ignore cmd_valid while busy; wr_valid outside WRITE has no effect.
REQ-031 SHALL hold addr1 at its last value when idle; data_in1 don't-care when we1=0.

Reset
REQ-032 SHALL, when rst=0 at a posedge, set state IDLE, beat counter 0, we1=0, addr1=0, data_in1=0, rd_valid=0, rd_data=0, done=0, busy=0, cmd_ready=0.
REQ-033 SHALL assert cmd_ready in the first cycle after rst returns to 1.
REQ-034 SHALL abort any burst on mid-burst reset; in-flight reads produce no rd_valid after reset.

Structure
REQ-035 SHALL take ADDR_W/DATA_W defaults and the state enum from shared package dpram_pkg.
REQ-036 SHALL keep read-latency alignment in one sub-module, dpram_rd_pipe (2-stage valid shift register plus data capture).
REQ-037 SHALL connect to the DPRAM through the TB-side port-1 signal set (addr1, data_in1, we1, data_out1) of the existing DPRAM interface.

Verification
REQ-038 Write burst addr=2 len=3 data A,B,C,D back-to-back -> we1 high 4 cycles, addr1 2,3,4,5, done pulse once, busy low after.
REQ-039 Read burst addr=2 len=3 after REQ-038 -> rd_valid 4 consecutive cycles, rd_data A,B,C,D, first rd_valid 2 cycles after addr1=2.
REQ-040 Write addr=14 len=3 data 1,2,3,4 then read same -> addr1 14,15,0,1; read returns 1,2,3,4.
REQ-041 Write burst with wr_valid deasserted every other cycle -> we1 only on handshake cycles, 4 total writes, no duplicated beats.
REQ-042 rst=0 mid-read after 2 addresses issued -> no further rd_valid, we1=0, cmd_ready=1 first cycle after release.
REQ-043 cmd_valid held high during active burst -> second command accepted only the cycle after done.
